pipeline_stall_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage MIPS32 pipeline.
- Combines three hazard sources into per-stage write-enables and flushes:
  - load-use hazards (ID vs EX),
  - the iterative mult/div unit's busy window,
  - data-memory wait.
- Owns the mult/div latency counter and a stall-cycle performance counter.
- Sits between the ID/EX/MEM stage control signals and the PC plus the IF/ID, ID/EX and EX/MEM pipeline registers.

---
 rtl/pipeline_stall_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS32 pipeline: merges load-use,
// mult/div busy and data-memory wait hazards into per-stage enables and flushes.
module pipeline_stall_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       rtEX,
    input  logic             memReadEX,
    input  logic             isBranch,
    input  logic             mdStart,
    input  logic             mdRead,
    input  logic             memBusy,
    input  logic             statClear,
    output logic             pcWrite,
    output logic             ifIdWrite,
    output logic             idExWrite,
    output logic             exMemWrite,
    output logic             ifIdFlush,
    output logic             idExFlush,
    output logic             exMemFlush,
    output logic             mdBusy,
    output logic             mdDone,
    output logic [CNT_W-1:0] stallCycles
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] BUSY    = 1'b1;
    localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 1);

    logic [0:0]       stateReg, stateNext;
    logic [7:0]       mdCountReg, mdCountNext;
    logic [CNT_W-1:0] stallReg, stallNext;

    logic       busy;
    logic       loadUse;
    logic       accept;
    logic       hiloHaz;
    logic [4:0] srcReg [2];
    logic [1:0] srcHit;

    assign srcReg[0] = rs;
    assign srcReg[1] = rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gSrcCmp
            assign srcHit[gi] = (srcReg[gi] == rtEX);
        end
    endgenerate

    // $zero is hard-wired, so a load targeting it can never create a hazard
    assign busy    = (stateReg == BUSY);
    assign loadUse = memReadEX & (rtEX != 5'd0) & (|srcHit);
    assign accept  = mdStart & ~busy & ~memBusy;
    assign hiloHaz = mdRead & (busy | accept);

    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        idExWrite  = 1'b1;
        exMemWrite = 1'b1;
        ifIdFlush  = 1'b0;
        idExFlush  = 1'b0;
        exMemFlush = 1'b0;
        if (Reset) begin
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
            exMemFlush = 1'b1;
        end else if (memBusy) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
        end else if (mdStart & busy) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemFlush = 1'b1;
        end else if (loadUse | hiloHaz) begin
            // a taken branch here is dropped; ID re-resolves it next cycle
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExFlush  = 1'b1;
        end else if (isBranch) begin
            ifIdFlush  = 1'b1;
        end
    end

    assign mdBusy = busy & ~Reset;
    assign mdDone = busy & (mdCountReg == 8'd1) & ~Reset;

    // the counter keeps running through a memory freeze
    always_comb begin
        stateNext   = stateReg;
        mdCountNext = mdCountReg;
        if (busy) begin
            if (mdCountReg == 8'd1) begin
                stateNext   = IDLE;
                mdCountNext = 8'd0;
            end else begin
                mdCountNext = mdCountReg - 8'd1;
            end
        end else if (accept) begin
            stateNext   = BUSY;
            mdCountNext = MD_LOAD;
        end
    end

    always_comb begin
        stallNext = stallReg;
        if (statClear) begin
            stallNext = '0;
        end else if (~pcWrite && (stallReg != {CNT_W{1'b1}})) begin
            stallNext = stallReg + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateReg   <= IDLE;
            mdCountReg <= 8'd0;
            stallReg   <= '0;
        end else begin
            stateReg   <= stateNext;
            mdCountReg <= mdCountNext;
            stallReg   <= stallNext;
        end
    end

    assign stallCycles = stallReg;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with MD_LATENCY=4, CNT_W=4.
module tb_pipeline_stall_ctrl;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [4:0] rs, rt, rtEX;
    logic       memReadEX, isBranch, mdStart, mdRead, memBusy, statClear;
    logic       pcWrite, ifIdWrite, idExWrite, exMemWrite;
    logic       ifIdFlush, idExFlush, exMemFlush, mdBusy, mdDone;
    logic [3:0] stallCycles;

    int         vectors = 0;
    int         errors  = 0;
    logic [3:0] expStall = 4'd0;
    logic [6:0] ctl;

    // {pc, ifId, idEx, exMem, ifIdFlush, idExFlush, exMemFlush}
    localparam logic [6:0] C_RUN    = 7'b1111000;
    localparam logic [6:0] C_FREEZE = 7'b0000000;
    localparam logic [6:0] C_STRUCT = 7'b0001001;
    localparam logic [6:0] C_LOADU  = 7'b0011010;
    localparam logic [6:0] C_BRANCH = 7'b1111100;
    localparam logic [6:0] C_RESET  = 7'b1111111;

    assign ctl = {pcWrite, ifIdWrite, idExWrite, exMemWrite, ifIdFlush, idExFlush, exMemFlush};

    always #5 Clock = ~Clock;

    pipeline_stall_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (
        .Clock(Clock), .Reset(Reset), .rs(rs), .rt(rt), .rtEX(rtEX),
        .memReadEX(memReadEX), .isBranch(isBranch), .mdStart(mdStart),
        .mdRead(mdRead), .memBusy(memBusy), .statClear(statClear),
        .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .idExWrite(idExWrite),
        .exMemWrite(exMemWrite), .ifIdFlush(ifIdFlush), .idExFlush(idExFlush),
        .exMemFlush(exMemFlush), .mdBusy(mdBusy), .mdDone(mdDone),
        .stallCycles(stallCycles)
    );

    task automatic clear_inputs();
        rs = 5'd0; rt = 5'd0; rtEX = 5'd0;
        memReadEX = 1'b0; isBranch = 1'b0; mdStart = 1'b0;
        mdRead = 1'b0; memBusy = 1'b0; statClear = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // one comparison of the stage controls plus mult/div flags, then advance a cycle
    task automatic cycle(input string name, input logic [6:0] expCtl,
                         input logic expBusy, input logic expDone);
        #2;
        vectors++;
        if (ctl !== expCtl || mdBusy !== expBusy || mdDone !== expDone) begin
            errors++;
            $display("FAIL %s: ctl=%b busy=%b done=%b, want ctl=%b busy=%b done=%b",
                     name, ctl, mdBusy, mdDone, expCtl, expBusy, expDone);
        end else begin
            $display("vec %0d %s: ctl=%b busy=%b done=%b", vectors, name, ctl, mdBusy, mdDone);
        end
        tick();
    endtask

    task automatic check_stall(input string name);
        vectors++;
        if (stallCycles !== expStall) begin
            errors++;
            $display("FAIL %s: stallCycles=%0d, want %0d", name, stallCycles, expStall);
        end else begin
            $display("vec %0d %s: stallCycles=%0d", vectors, name, stallCycles);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        Reset = 1'b1;
        cycle("reset_ctl", C_RESET, 1'b0, 1'b0);
        Reset = 1'b0;
        expStall = 4'd0;
        check_stall("reset_stall");
        cycle("post_reset_run", C_RUN, 1'b0, 1'b0);
    endtask

    task automatic test_load_use();
        memReadEX = 1'b1; rtEX = 5'd15; rs = 5'd15; rt = 5'd0;
        cycle("loaduse_rs", C_LOADU, 1'b0, 1'b0);
        expStall = expStall + 4'd1;
        check_stall("loaduse_count");
        rtEX = 5'd0; rs = 5'd0;
        cycle("loaduse_zero_reg", C_RUN, 1'b0, 1'b0);
        check_stall("zero_reg_count");
        clear_inputs();
    endtask

    task automatic test_branch();
        isBranch = 1'b1;
        cycle("branch_alone", C_BRANCH, 1'b0, 1'b0);
        memReadEX = 1'b1; rt = 5'd12; rtEX = 5'd12;
        cycle("branch_vs_loaduse", C_LOADU, 1'b0, 1'b0);
        expStall = expStall + 4'd1;
        check_stall("branch_count");
        clear_inputs();
    endtask

    task automatic test_md_latency();
        mdStart = 1'b1; mdRead = 1'b1;
        cycle("md_c0_hilo_accept", C_LOADU, 1'b0, 1'b0);
        mdStart = 1'b0;
        cycle("md_c1_hilo", C_LOADU, 1'b1, 1'b0);
        cycle("md_c2_hilo", C_LOADU, 1'b1, 1'b0);
        cycle("md_c3_done", C_LOADU, 1'b1, 1'b1);
        cycle("md_c4_idle", C_RUN, 1'b0, 1'b0);
        expStall = expStall + 4'd4;
        check_stall("md_count");
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        mdStart = 1'b1;
        cycle("b2b_c0_accept", C_RUN, 1'b0, 1'b0);
        mdStart = 1'b0;
        cycle("b2b_c1", C_RUN, 1'b1, 1'b0);
        mdStart = 1'b1;
        cycle("b2b_c2_struct", C_STRUCT, 1'b1, 1'b0);
        cycle("b2b_c3_struct_done", C_STRUCT, 1'b1, 1'b1);
        cycle("b2b_c4_accept", C_RUN, 1'b0, 1'b0);
        mdStart = 1'b0;
        cycle("b2b_c5", C_RUN, 1'b1, 1'b0);
        cycle("b2b_c6", C_RUN, 1'b1, 1'b0);
        cycle("b2b_c7_done", C_RUN, 1'b1, 1'b1);
        cycle("b2b_c8_idle", C_RUN, 1'b0, 1'b0);
        expStall = expStall + 4'd2;
        check_stall("b2b_count");
    endtask

    task automatic test_mem_busy();
        mdStart = 1'b1;
        cycle("mb_c0_accept", C_RUN, 1'b0, 1'b0);
        mdStart = 1'b0; memBusy = 1'b1;
        memReadEX = 1'b1; rs = 5'd7; rtEX = 5'd7; isBranch = 1'b1;
        cycle("mb_c1_freeze", C_FREEZE, 1'b1, 1'b0);
        cycle("mb_c2_freeze", C_FREEZE, 1'b1, 1'b0);
        cycle("mb_c3_freeze_done", C_FREEZE, 1'b1, 1'b1);
        clear_inputs();
        cycle("mb_c4_idle", C_RUN, 1'b0, 1'b0);
        expStall = expStall + 4'd3;
        check_stall("mb_count");
        memBusy = 1'b1; mdStart = 1'b1;
        cycle("mb_start_blocked", C_FREEZE, 1'b0, 1'b0);
        clear_inputs();
        cycle("mb_not_accepted", C_RUN, 1'b0, 1'b0);
        expStall = expStall + 4'd1;
        check_stall("mb_block_count");
    endtask

    task automatic test_reset_mid();
        mdStart = 1'b1;
        cycle("rm_c0_accept", C_RUN, 1'b0, 1'b0);
        mdStart = 1'b0;
        cycle("rm_c1", C_RUN, 1'b1, 1'b0);
        Reset = 1'b1;
        cycle("rm_c2_reset", C_RESET, 1'b0, 1'b0);
        Reset = 1'b0;
        expStall = 4'd0;
        check_stall("rm_stall_cleared");
        cycle("rm_idle", C_RUN, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        memBusy = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        expStall = 4'd15;
        check_stall("saturate_15");
        statClear = 1'b1;
        tick();
        expStall = 4'd0;
        check_stall("clear_over_stall");
        statClear = 1'b0;
        tick();
        expStall = 4'd1;
        check_stall("count_after_clear");
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_md_latency();
        test_back_to_back();
        test_mem_busy();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
